// File: rtl/ex_req_gen.sv
// Exception/interrupt request generator: synchronizes external interrupts, latches pending
// bits and issues one registered exception or eret pulse from the write-back stage.
module ex_req_gen #(
    parameter int SYNC_STAGES = 2,
    parameter int FLUSH_HOLD  = 2
) (
    input  logic        mem_clk,
    input  logic        rst,
    input  logic [5:0]  irq_in,
    input  logic        ie,
    input  logic        exl,
    input  logic        hlt,
    input  logic [7:0]  int_mask,
    input  logic [1:0]  sw_int,
    input  logic        wb_valid,
    input  logic [31:0] wb_pc,
    input  logic        wb_bd,
    input  logic [8:0]  wb_flags,
    output logic        ex_out,
    output logic [4:0]  ex_code_out,
    output logic [31:0] epc_out,
    output logic        bd_out,
    output logic        eret_flush_out,
    output logic [5:0]  int_sig_out,
    output logic        busy
);

    localparam logic [4:0] CODE_INT    = 5'h00;
    localparam logic [4:0] CODE_HLT    = 5'h01;
    localparam logic [4:0] CODE_RESUME = 5'h02;
    localparam logic [4:0] CODE_ADEL   = 5'h04;
    localparam logic [4:0] CODE_ADES   = 5'h05;
    localparam logic [4:0] CODE_SYS    = 5'h08;
    localparam logic [4:0] CODE_BP     = 5'h09;
    localparam logic [4:0] CODE_RI     = 5'h0a;
    localparam logic [4:0] CODE_OF     = 5'h0c;
    localparam logic [2:0] HOLD_LAST   = 3'(FLUSH_HOLD - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, HOLD} state_t;

    state_t      state, state_next;
    logic [2:0]  hold_cnt, hold_cnt_next;

    logic [5:0]  sync_q [SYNC_STAGES];
    logic [SYNC_STAGES-1:0] sync_vld;
    logic [5:0]  irq_sync, irq_prev, armed, rise;
    logic [5:0]  pending, int_clr;
    logic        int_req;

    logic        sel_ex, sel_eret, sel_int, sel_bd;
    logic [4:0]  sel_code;
    logic [31:0] sel_epc;
    logic        can_issue, take_int;
    logic        ex_next, eret_next, bd_next;
    logic [4:0]  code_next;
    logic [31:0] epc_next;

    assign irq_sync    = sync_q[SYNC_STAGES-1];
    // A line only arms after a genuine low sample, so a line high at reset release is ignored
    assign rise        = armed & irq_sync & ~irq_prev;
    assign int_req     = ie & ~exl & (|(int_mask & {pending, sw_int}));
    assign int_sig_out = pending;
    assign busy        = (state != IDLE);

    always_ff @(posedge mem_clk) begin
        if (rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
            sync_vld <= '0;
            irq_prev <= '0;
            armed    <= '0;
            pending  <= '0;
        end else begin
            sync_q[0] <= irq_in;
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
            sync_vld <= {sync_vld[SYNC_STAGES-2:0], 1'b1};
            irq_prev <= irq_sync;
            armed    <= armed | ({6{sync_vld[SYNC_STAGES-1]}} & ~irq_sync);
            pending  <= (pending & ~(take_int ? int_clr : 6'b0)) | rise;
        end
    end

    always_comb begin
        int_clr = '0;
        for (int i = 0; i < 6; i++) begin
            if (pending[i] && int_mask[i+2]) begin
                int_clr    = '0;
                int_clr[i] = 1'b1;
            end
        end
    end

    // Exception selection for the current write-back instruction
    always_comb begin
        sel_ex   = 1'b0;
        sel_eret = 1'b0;
        sel_int  = 1'b0;
        sel_code = '0;
        sel_epc  = '0;
        sel_bd   = 1'b0;
        if (hlt) begin
            if (int_req) begin
                sel_ex  = 1'b1;
                sel_int = 1'b1;
                sel_code = CODE_INT;
            end else if (wb_valid && wb_flags[8]) begin
                sel_ex   = 1'b1;
                sel_code = CODE_RESUME;
                sel_epc  = wb_pc;
                sel_bd   = wb_bd;
            end
        end else if (wb_valid) begin
            sel_ex  = 1'b1;
            sel_epc = wb_pc;
            sel_bd  = wb_bd;
            if (int_req) begin
                sel_int  = 1'b1;
                sel_code = CODE_INT;
            end
            else if (wb_flags[1]) sel_code = CODE_ADEL;
            else if (wb_flags[2]) sel_code = CODE_ADES;
            else if (wb_flags[3]) sel_code = CODE_SYS;
            else if (wb_flags[4]) sel_code = CODE_BP;
            else if (wb_flags[5]) sel_code = CODE_RI;
            else if (wb_flags[6]) sel_code = CODE_OF;
            else if (wb_flags[7]) sel_code = CODE_HLT;
            else if (wb_flags[8]) sel_code = CODE_RESUME;
            else begin
                sel_ex   = 1'b0;
                sel_epc  = '0;
                sel_bd   = 1'b0;
                sel_eret = wb_flags[0];
            end
        end
    end

    // The final HOLD cycle decides like IDLE, so a held request reissues FLUSH_HOLD+1 cycles later
    always_comb begin
        state_next    = state;
        hold_cnt_next = hold_cnt;
        ex_next       = 1'b0;
        eret_next     = 1'b0;
        code_next     = '0;
        epc_next      = '0;
        bd_next       = 1'b0;
        take_int      = 1'b0;
        can_issue     = (state == IDLE) || (state == HOLD && hold_cnt == HOLD_LAST);
        if (state == ISSUE) begin
            state_next    = HOLD;
            hold_cnt_next = '0;
        end else if (can_issue && (sel_ex || sel_eret)) begin
            state_next = ISSUE;
            ex_next    = sel_ex;
            eret_next  = sel_eret;
            code_next  = sel_code;
            epc_next   = sel_epc;
            bd_next    = sel_bd;
            take_int   = sel_ex & sel_int;
        end else if (state == HOLD) begin
            if (hold_cnt == HOLD_LAST) state_next = IDLE;
            else hold_cnt_next = hold_cnt + 3'd1;
        end
    end

    always_ff @(posedge mem_clk) begin
        if (rst) begin
            state          <= IDLE;
            hold_cnt       <= '0;
            ex_out         <= 1'b0;
            eret_flush_out <= 1'b0;
            ex_code_out    <= '0;
            epc_out        <= '0;
            bd_out         <= 1'b0;
        end else begin
            state          <= state_next;
            hold_cnt       <= hold_cnt_next;
            ex_out         <= ex_next;
            eret_flush_out <= eret_next;
            ex_code_out    <= code_next;
            epc_out        <= epc_next;
            bd_out         <= bd_next;
        end
    end

endmodule

// File: tb/tb_ex_req_gen.sv
// Directed self-checking bench for ex_req_gen (default parameters: 2 sync stages, hold of 2).
module tb_ex_req_gen;

    logic        mem_clk;
    logic        rst;
    logic [5:0]  irq_in;
    logic        ie, exl, hlt;
    logic [7:0]  int_mask;
    logic [1:0]  sw_int;
    logic        wb_valid;
    logic [31:0] wb_pc;
    logic        wb_bd;
    logic [8:0]  wb_flags;
    logic        ex_out;
    logic [4:0]  ex_code_out;
    logic [31:0] epc_out;
    logic        bd_out;
    logic        eret_flush_out;
    logic [5:0]  int_sig_out;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;

    ex_req_gen #(.SYNC_STAGES(2), .FLUSH_HOLD(2)) dut (
        .mem_clk(mem_clk), .rst(rst), .irq_in(irq_in), .ie(ie), .exl(exl), .hlt(hlt),
        .int_mask(int_mask), .sw_int(sw_int), .wb_valid(wb_valid), .wb_pc(wb_pc),
        .wb_bd(wb_bd), .wb_flags(wb_flags), .ex_out(ex_out), .ex_code_out(ex_code_out),
        .epc_out(epc_out), .bd_out(bd_out), .eret_flush_out(eret_flush_out),
        .int_sig_out(int_sig_out), .busy(busy)
    );

    initial mem_clk = 1'b0;
    always #5 mem_clk = ~mem_clk;

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge mem_clk);
            #1;
        end
    endtask

    task automatic idle_inputs();
        wb_valid = 1'b0;
        wb_flags = '0;
        wb_bd    = 1'b0;
        ie       = 1'b0;
        hlt      = 1'b0;
        sw_int   = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1; irq_in = '0; exl = 1'b0; int_mask = 8'hFF; wb_pc = '0;
        idle_inputs();
        tick(2);
        n_checks++; if (ex_out !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_ex: got %0b want 0", ex_out); end
        n_checks++; if (eret_flush_out !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_eret: got %0b want 0", eret_flush_out); end
        n_checks++; if (epc_out !== 32'h0 || ex_code_out !== 5'h0 || bd_out !== 1'b0) begin
            n_fail++; $display("[TB] FAIL reset_fields: epc=%h code=%h bd=%0b want 0", epc_out, ex_code_out, bd_out); end
        n_checks++; if (int_sig_out !== 6'h0) begin n_fail++; $display("[TB] FAIL reset_int_sig: got %b want 0", int_sig_out); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_busy: got %0b want 0", busy); end
        rst = 1'b0;
        tick(5);
    endtask

    task automatic test_irq();
        ie = 1'b1; int_mask = 8'hFF; wb_valid = 1'b1; wb_pc = 32'h0040_0100;
        irq_in[3] = 1'b1;
        tick(3);
        n_checks++; if (int_sig_out !== 6'b001000) begin n_fail++; $display("[TB] FAIL irq_pending: got %b want 001000", int_sig_out); end
        n_checks++; if (ex_out !== 1'b0) begin n_fail++; $display("[TB] FAIL irq_early: ex_out=%0b want 0", ex_out); end
        tick(1);
        n_checks++; if (ex_out !== 1'b1 || ex_code_out !== 5'h00 || epc_out !== 32'h0040_0100) begin
            n_fail++; $display("[TB] FAIL irq_issue: ex=%0b code=%h epc=%h want 1/00/00400100", ex_out, ex_code_out, epc_out); end
        n_checks++; if (int_sig_out !== 6'b000000) begin n_fail++; $display("[TB] FAIL irq_clear: got %b want 000000", int_sig_out); end
        tick(1);
        n_checks++; if (ex_out !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("[TB] FAIL irq_hold: ex=%0b busy=%0b want 0/1", ex_out, busy); end
        wb_valid = 1'b0;
        tick(2);
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL irq_idle: busy=%0b want 0", busy); end
        irq_in = '0; ie = 1'b0;
        tick(3);
    endtask

    task automatic test_int_clear();
        irq_in = 6'b010010;
        tick(3);
        n_checks++; if (int_sig_out !== 6'b010010) begin n_fail++; $display("[TB] FAIL clr_pending: got %b want 010010", int_sig_out); end
        ie = 1'b1; wb_valid = 1'b1; wb_pc = 32'h0040_0500;
        tick(1);
        n_checks++; if (ex_out !== 1'b1 || int_sig_out !== 6'b000010) begin
            n_fail++; $display("[TB] FAIL clr_highest: ex=%0b pend=%b want 1/000010", ex_out, int_sig_out); end
        tick(1);
        n_checks++; if (ex_out !== 1'b0) begin n_fail++; $display("[TB] FAIL clr_gap1: ex=%0b want 0", ex_out); end
        tick(1);
        n_checks++; if (ex_out !== 1'b0) begin n_fail++; $display("[TB] FAIL clr_gap2: ex=%0b want 0", ex_out); end
        tick(1);
        n_checks++; if (ex_out !== 1'b1 || int_sig_out !== 6'b000000 || epc_out !== 32'h0040_0500) begin
            n_fail++; $display("[TB] FAIL clr_second: ex=%0b pend=%b epc=%h want 1/000000/00400500", ex_out, int_sig_out, epc_out); end
        idle_inputs(); irq_in = '0;
        tick(4);
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL clr_idle: busy=%0b want 0", busy); end
    endtask

    task automatic test_adel();
        wb_valid = 1'b1; wb_flags = 9'h022; wb_bd = 1'b1; wb_pc = 32'h0040_0204;
        tick(1);
        n_checks++; if (ex_out !== 1'b1 || ex_code_out !== 5'h04 || epc_out !== 32'h0040_0204 || bd_out !== 1'b1) begin
            n_fail++; $display("[TB] FAIL adel_issue: ex=%0b code=%h epc=%h bd=%0b want 1/04/00400204/1", ex_out, ex_code_out, epc_out, bd_out); end
        idle_inputs();
        for (int i = 0; i < 2; i++) begin
            tick(1);
            n_checks++; if (busy !== 1'b1 || ex_out !== 1'b0 || ex_code_out !== 5'h0 || bd_out !== 1'b0) begin
                n_fail++; $display("[TB] FAIL adel_hold%0d: busy=%0b ex=%0b code=%h bd=%0b want 1/0/00/0", i, busy, ex_out, ex_code_out, bd_out); end
        end
        tick(1);
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL adel_busy_end: busy=%0b want 0", busy); end
    endtask

    task automatic test_eret();
        wb_valid = 1'b1; wb_flags = 9'h001; wb_pc = 32'h0040_0400;
        tick(1);
        n_checks++; if (eret_flush_out !== 1'b1 || ex_out !== 1'b0) begin
            n_fail++; $display("[TB] FAIL eret_pulse: eret=%0b ex=%0b want 1/0", eret_flush_out, ex_out); end
        idle_inputs();
        tick(1);
        n_checks++; if (eret_flush_out !== 1'b0) begin n_fail++; $display("[TB] FAIL eret_width: eret=%0b want 0", eret_flush_out); end
        tick(3);
        wb_valid = 1'b1; wb_flags = 9'h009;
        tick(1);
        n_checks++; if (ex_out !== 1'b1 || ex_code_out !== 5'h08 || eret_flush_out !== 1'b0) begin
            n_fail++; $display("[TB] FAIL eret_sys: ex=%0b code=%h eret=%0b want 1/08/0", ex_out, ex_code_out, eret_flush_out); end
        idle_inputs();
        tick(4);
    endtask

    task automatic test_halt();
        hlt = 1'b1; wb_valid = 1'b1; wb_flags = 9'h008; wb_pc = 32'h0040_0280;
        tick(2);
        n_checks++; if (ex_out !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("[TB] FAIL halt_ignore: ex=%0b busy=%0b want 0/0", ex_out, busy); end
        wb_flags = 9'h100; wb_pc = 32'h0040_0300;
        tick(1);
        n_checks++; if (ex_out !== 1'b1 || ex_code_out !== 5'h02 || epc_out !== 32'h0040_0300) begin
            n_fail++; $display("[TB] FAIL halt_resume: ex=%0b code=%h epc=%h want 1/02/00400300", ex_out, ex_code_out, epc_out); end
        idle_inputs();
        tick(4);
        hlt = 1'b1; ie = 1'b1; sw_int = 2'b01; wb_valid = 1'b1; wb_bd = 1'b1; wb_pc = 32'h0040_0600;
        tick(1);
        n_checks++; if (ex_out !== 1'b1 || ex_code_out !== 5'h00 || epc_out !== 32'h0 || bd_out !== 1'b0) begin
            n_fail++; $display("[TB] FAIL halt_int: ex=%0b code=%h epc=%h bd=%0b want 1/00/00000000/0", ex_out, ex_code_out, epc_out, bd_out); end
        idle_inputs();
        tick(4);
    endtask

    task automatic test_back_to_back();
        wb_valid = 1'b1; wb_flags = 9'h008; wb_pc = 32'h0040_0700;
        tick(1);
        n_checks++; if (ex_out !== 1'b1 || ex_code_out !== 5'h08) begin
            n_fail++; $display("[TB] FAIL b2b_first: ex=%0b code=%h want 1/08", ex_out, ex_code_out); end
        for (int i = 0; i < 2; i++) begin
            tick(1);
            n_checks++; if (ex_out !== 1'b0) begin n_fail++; $display("[TB] FAIL b2b_gap%0d: ex=%0b want 0", i, ex_out); end
        end
        tick(1);
        n_checks++; if (ex_out !== 1'b1 || epc_out !== 32'h0040_0700) begin
            n_fail++; $display("[TB] FAIL b2b_second: ex=%0b epc=%h want 1/00400700", ex_out, epc_out); end
        idle_inputs();
        tick(4);
    endtask

    task automatic test_reset_mid_hold();
        irq_in[5] = 1'b1;
        tick(3);
        n_checks++; if (int_sig_out !== 6'b100000) begin n_fail++; $display("[TB] FAIL rsth_pending: got %b want 100000", int_sig_out); end
        wb_valid = 1'b1; wb_flags = 9'h008; wb_pc = 32'h0040_0800;
        tick(1);
        wb_valid = 1'b0; wb_flags = '0;
        tick(1);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        n_checks++; if (ex_out !== 1'b0 || busy !== 1'b0 || int_sig_out !== 6'h0 || epc_out !== 32'h0 || ex_code_out !== 5'h0) begin
            n_fail++; $display("[TB] FAIL rsth_clear: ex=%0b busy=%0b pend=%b epc=%h code=%h want all 0", ex_out, busy, int_sig_out, epc_out, ex_code_out); end
        ie = 1'b1; int_mask = 8'hFF; wb_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick(1);
            n_checks++; if (ex_out !== 1'b0 || int_sig_out !== 6'h0) begin
                n_fail++; $display("[TB] FAIL rsth_no_int%0d: ex=%0b pend=%b want 0/000000", i, ex_out, int_sig_out); end
        end
        irq_in[5] = 1'b0;
        tick(4);
        irq_in[5] = 1'b1;
        tick(3);
        n_checks++; if (int_sig_out !== 6'b100000 || ex_out !== 1'b0) begin
            n_fail++; $display("[TB] FAIL rsth_repend: pend=%b ex=%0b want 100000/0", int_sig_out, ex_out); end
        tick(1);
        n_checks++; if (ex_out !== 1'b1 || ex_code_out !== 5'h00 || epc_out !== 32'h0040_0800) begin
            n_fail++; $display("[TB] FAIL rsth_issue: ex=%0b code=%h epc=%h want 1/00/00400800", ex_out, ex_code_out, epc_out); end
        idle_inputs(); irq_in = '0;
        tick(4);
    endtask

    initial begin
        test_reset();
        test_irq();
        test_int_clear();
        test_adel();
        test_eret();
        test_halt();
        test_back_to_back();
        test_reset_mid_hold();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ex_req_gen.md
EX_REQ_GEN -- requirements
Module: ex_req_gen

Interface
REQ-001 Parameter SYNC_STAGES, default 2: synchronizer depth for irq_in, legal range 2..3.
REQ-002 Parameter FLUSH_HOLD, default 2: cycles during which new requests are blocked after an issue, legal range 1..7.
REQ-003 mem_clk  in  1  clock; all state updates on posedge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 irq_in  in  6  asynchronous external interrupt lines; bit 5 has highest priority.
REQ-006 ie, exl, hlt  in  1 each  status bits from coprocessor 0.
REQ-007 int_mask  in  8  interrupt mask from coprocessor 0.
REQ-008 sw_int  in  2  software interrupt bits (coprocessor 0 cause IP1..IP0).
REQ-009 wb_valid  in  1  write-back stage holds a valid instruction.
REQ-010 wb_pc  in  32  PC of the write-back instruction.
REQ-011 wb_bd  in  1  the write-back instruction is in a branch delay slot.
REQ-012 wb_flags  in  9  per-instruction flags: {resume, hlt, of, ri, bp, sys, ades, adel, eret}, in bit order [8:0].
REQ-013 ex_out  out  1  exception commit pulse; drives coprocessor 0 ex_wb_in.
REQ-014 ex_code_out  out  5  exception code.
REQ-015 epc_out  out  32  victim PC.
REQ-016 bd_out  out  1  branch-delay flag of the victim.
REQ-017 eret_flush_out  out  1  eret commit pulse.
REQ-018 int_sig_out  out  6  latched hardware pending bits; drive coprocessor 0 int_sig_in.
REQ-019 busy  out  1  high while the state is ISSUE or HOLD.

Function
REQ-020 irq_in passes through SYNC_STAGES flops; a 0->1 transition on a synchronized bit sets pending[i].
REQ-021 int_sig_out = pending, registered.
REQ-022 int_req = ie & !exl & |(int_mask & {pending, sw_int}).
REQ-023 FSM states are IDLE, ISSUE and HOLD; outputs are registered, so the response follows the sampled condition by 1 cycle.
REQ-024 Normal mode (IDLE, hlt=0, wb_valid=1): exception selection priority is INT(0x00) > ADEL(0x04) > ADES(0x05) > SYS(0x08) > BP(0x09) > RI(0x0a) > OF(0x0c) > HLT(0x01) > RESUME(0x02).
REQ-025 Normal mode: if any exception is selected, the FSM goes to ISSUE with ex_out=1, ex_code_out=selected code, epc_out=wb_pc, bd_out=wb_bd.
REQ-026 Normal mode: if no exception is selected and eret=1, the FSM goes to ISSUE with eret_flush_out=1 and ex_out=0.
REQ-027 An exception and eret in the same instruction: the exception wins and eret_flush_out stays 0.
REQ-028 Halt mode (IDLE, hlt=1): wb_valid and all wb_flags except resume are ignored.
REQ-029 Halt mode: int_req issues INT with epc_out=0 and bd_out=0; otherwise, wb_valid & resume issues RESUME with epc_out=wb_pc.
REQ-030 ISSUE lasts exactly 1 cycle and then goes to HOLD; ex_out and eret_flush_out are never high for 2 consecutive cycles.
REQ-031 HOLD lasts FLUSH_HOLD cycles, ignores wb_valid and int_req, and then goes to IDLE; a request still present on IDLE entry issues on the next edge.
REQ-032 On INT issue, clear the highest-index i with pending[i] & int_mask[i+2]; if only a software source caused the interrupt, clear nothing.
REQ-033 Set-vs-clear on the same bit in the same cycle: set wins.
REQ-034 In IDLE and HOLD, ex_out, eret_flush_out, ex_code_out, epc_out and bd_out are 0.
REQ-035 Pending bits continue to latch in every state.

Reset
REQ-036 rst=1 for one edge forces the following: FSM=IDLE, HOLD counter=0, pending=0, synchronizer flops=0, all outputs 0.
REQ-037 Reset mid-ISSUE or mid-HOLD aborts the sequence; no pulse appears after reset.
REQ-038 A synchronized irq line that is already high at reset release does not set pending until it falls and rises again.

Verification
REQ-039 ie=1, exl=0, int_mask=0xFF, irq_in[3] rises, wb_valid=1, wb_pc=0x400100 -> pending[3] after SYNC_STAGES+1 edges; next cycle ex_out=1, code 0x00, epc 0x400100; pending[3] cleared.
REQ-040 wb_flags adel+ri, wb_bd=1, wb_pc=0x400204 -> one ex_out pulse, code 0x04, epc_out=0x400204, bd_out=1, busy for 1+FLUSH_HOLD cycles.
REQ-041 eret only -> eret_flush_out pulse of 1 cycle, ex_out=0; eret+sys -> ex_out with code 0x08 and eret_flush_out=0.
REQ-042 hlt=1 with wb_valid and sys set -> no output; then resume at wb_pc=0x400300 -> code 0x02, epc_out=0x400300.
REQ-043 sys issued, then sys held constant -> second pulse exactly FLUSH_HOLD+1 cycles after the first.
REQ-044 rst asserted during HOLD with irq_in[5] high -> all outputs 0 and pending=0; no INT issue until irq_in[5] toggles low then high.
